// File: rtl/mips_pkg.sv
// Shared MIPS opcode/funct constants and the instruction-class decode used by issue.
// Opcode numbering is the local encoding, not the textbook one.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h12;
   localparam logic [5:0] OP_ORI   = 6'h13;
   localparam logic [5:0] OP_LUI   = 6'h15;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_LBU   = 6'h24;
   localparam logic [5:0] OP_LHU   = 6'h25;
   localparam logic [5:0] OP_SB    = 6'h28;
   localparam logic [5:0] OP_SH    = 6'h29;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_LL    = 6'h30;

   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_SLT  = 6'h2A;

   typedef struct packed {
      logic       reg_write;
      logic [4:0] dest;
      logic       use_rs;
      logic       use_rt;
   } decode_t;

   function automatic decode_t decode(input logic [31:0] instr);
      decode_t d;
      d.reg_write = 1'b0;
      d.dest      = instr[20:16];
      d.use_rs    = 1'b1;
      d.use_rt    = 1'b0;
      case (instr[31:26])
         OP_RTYPE: begin
            d.reg_write = 1'b1;
            d.dest      = instr[15:11];
            d.use_rt    = 1'b1;
            // shifts take their amount from shamt, not rs
            if (instr[5:0] == FN_SLL || instr[5:0] == FN_SRL || instr[5:0] == FN_SRA)
               d.use_rs = 1'b0;
         end
         OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_SLTI, OP_SLTIU,
         OP_LW, OP_LBU, OP_LHU, OP_LL:
            d.reg_write = 1'b1;
         OP_LUI: begin
            d.reg_write = 1'b1;
            d.use_rs    = 1'b0;
         end
         OP_BEQ, OP_BNE, OP_SB, OP_SH, OP_SW:
            d.use_rt = 1'b1;
         default: ;
      endcase
      if (d.dest == 5'd0)
         d.reg_write = 1'b0;
      return d;
   endfunction

endpackage

// File: rtl/mips_decode_issue_if.sv
// Issue-stage bundle: instruction input, write-back port, flush and the ALU-facing output entry.
interface mips_decode_issue_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr;
   logic [31:0] in_pc;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [4:0]  shamt;
   logic [15:0] immediate;
   logic [31:0] rs_content;
   logic [31:0] rt_content;
   logic [4:0]  dest_addr;
   logic        reg_write;
   logic [31:0] out_pc;

   modport master (
      output in_valid, instr, in_pc, wb_en, wb_addr, wb_data, flush, out_ready,
      input  in_ready, out_valid, opcode, funct, shamt, immediate,
             rs_content, rt_content, dest_addr, reg_write, out_pc
   );

   modport slave (
      input  in_valid, instr, in_pc, wb_en, wb_addr, wb_data, flush, out_ready,
      output in_ready, out_valid, opcode, funct, shamt, immediate,
             rs_content, rt_content, dest_addr, reg_write, out_pc
   );
endinterface

// File: rtl/mips_regfile.sv
// 32x32 register file, r0 hardwired to zero, two async read ports that see a same-cycle write.
module mips_regfile (
   input  logic        clk,
   input  logic        rst,
   input  logic        we,
   input  logic [4:0]  waddr,
   input  logic [31:0] wdata,
   input  logic [4:0]  raddr_a,
   input  logic [4:0]  raddr_b,
   output logic [31:0] rdata_a,
   output logic [31:0] rdata_b
);
   logic [31:0] mem [32];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++)
            mem[i] <= '0;
      end else if (we && waddr != 5'd0) begin
         mem[waddr] <= wdata;
      end
   end

   always_comb begin
      rdata_a = mem[raddr_a];
      if (raddr_a == 5'd0)
         rdata_a = '0;
      else if (we && waddr == raddr_a)
         rdata_a = wdata;
   end

   always_comb begin
      rdata_b = mem[raddr_b];
      if (raddr_b == 5'd0)
         rdata_b = '0;
      else if (we && waddr == raddr_b)
         rdata_b = wdata;
   end
endmodule

// File: rtl/mips_decode_issue.sv
// Decode/issue stage: field split, operand read, busy scoreboard and a one-entry output register.
module mips_decode_issue
   import mips_pkg::*;
(
   input logic               clk,
   input logic               rst,
   mips_decode_issue_if.slave bus
);
   decode_t     dec;
   logic [4:0]  rs_idx;
   logic [4:0]  rt_idx;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic [31:0] busy;
   logic [31:0] busy_eff;
   logic [31:0] busy_nxt;
   logic [31:0] wb_mask;
   logic        hazard;
   logic        in_ready;
   logic        accept;

   logic        out_valid_q;
   logic [5:0]  opcode_q;
   logic [5:0]  funct_q;
   logic [4:0]  shamt_q;
   logic [15:0] imm_q;
   logic [31:0] rs_q;
   logic [31:0] rt_q;
   logic [4:0]  dest_q;
   logic        rw_q;
   logic [31:0] pc_q;

   assign rs_idx = bus.instr[25:21];
   assign rt_idx = bus.instr[20:16];
   assign dec    = decode(bus.instr);

   mips_regfile u_regfile (
      .clk     (clk),
      .rst     (rst),
      .we      (bus.wb_en),
      .waddr   (bus.wb_addr),
      .wdata   (bus.wb_data),
      .raddr_a (rs_idx),
      .raddr_b (rt_idx),
      .rdata_a (rs_val),
      .rdata_b (rt_val)
   );

   // a write-back landing this cycle already releases its register for issue
   assign wb_mask  = bus.wb_en ? (32'd1 << bus.wb_addr) : 32'd0;
   assign busy_eff = busy & ~wb_mask;

   always_comb begin
      hazard = bus.in_valid &&
               ((dec.use_rs && rs_idx != 5'd0 && busy_eff[rs_idx]) ||
                (dec.use_rt && rt_idx != 5'd0 && busy_eff[rt_idx]) ||
                (dec.reg_write && busy_eff[dec.dest]));
   end

   assign in_ready = !hazard && !bus.flush && (!out_valid_q || bus.out_ready);
   assign accept   = bus.in_valid && in_ready;

   always_comb begin
      busy_nxt = busy_eff;
      if (bus.flush && out_valid_q && rw_q)
         busy_nxt[dest_q] = 1'b0;
      if (accept && dec.reg_write)
         busy_nxt[dec.dest] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         busy <= '0;
      else
         busy <= busy_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         opcode_q    <= '0;
         funct_q     <= '0;
         shamt_q     <= '0;
         imm_q       <= '0;
         rs_q        <= '0;
         rt_q        <= '0;
         dest_q      <= '0;
         rw_q        <= 1'b0;
         pc_q        <= '0;
      end else if (bus.flush) begin
         out_valid_q <= 1'b0;
      end else if (accept) begin
         out_valid_q <= 1'b1;
         opcode_q    <= bus.instr[31:26];
         funct_q     <= bus.instr[5:0];
         shamt_q     <= bus.instr[10:6];
         imm_q       <= bus.instr[15:0];
         rs_q        <= rs_val;
         rt_q        <= rt_val;
         dest_q      <= dec.dest;
         rw_q        <= dec.reg_write;
         pc_q        <= bus.in_pc;
      end else if (bus.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.out_valid  = out_valid_q;
   assign bus.opcode     = opcode_q;
   assign bus.funct      = funct_q;
   assign bus.shamt      = shamt_q;
   assign bus.immediate  = imm_q;
   assign bus.rs_content = rs_q;
   assign bus.rt_content = rt_q;
   assign bus.dest_addr  = dest_q;
   assign bus.reg_write  = rw_q;
   assign bus.out_pc     = pc_q;
endmodule
